// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register busy (pending-producer) bits.
// Optional same-cycle write-to-read forwarding; register 0 is hardwired to zero.
module regfile_mp_rdport #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic [NREG-1:0][XLEN-1:0] i_regs,
  input  logic [NREG-1:0]           i_busy,
  input  logic [NWR-1:0]            i_wr_en,
  input  logic [NWR*AW-1:0]         i_wr_addr,
  input  logic [NWR*XLEN-1:0]       i_wr_data,
  input  logic [AW-1:0]             i_addr,
  output logic [XLEN-1:0]           o_data,
  output logic                      o_busy
);
  logic [XLEN-1:0] w_fwd;
  logic            w_hit;

  // Ascending scan so the highest-numbered matching port is the one kept.
  always_comb begin
    w_fwd = '0;
    w_hit = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == i_addr) && (i_addr != '0)) begin
        w_fwd = i_wr_data[p*XLEN +: XLEN];
        w_hit = 1'b1;
      end
    end
  end

  always_comb begin
    o_data = (i_addr == '0) ? '0 : i_regs[i_addr];
    o_busy = i_busy[i_addr];
    if ((BYPASS != 0) && w_hit) begin
      o_data = w_fwd;
      o_busy = 1'b0;
    end
  end
endmodule

module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 resv_en,
  input  logic [AW-1:0]        resv_addr,
  input  logic                 flush
);
  logic [NREG-1:0][XLEN-1:0] r_regs;
  logic [NREG-1:0]           r_busy;
  logic [NREG-1:0][XLEN-1:0] w_regs_nxt;
  logic [NREG-1:0]           w_busy_nxt;

  // A reservation in the same cycle as a write is the newer producer, so it
  // is applied after the write clears; flush trumps both.
  always_comb begin
    w_regs_nxt = r_regs;
    w_busy_nxt = r_busy;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
        w_regs_nxt[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
        w_busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (resv_en && (resv_addr != '0)) w_busy_nxt[resv_addr] = 1'b1;
    if (flush) w_busy_nxt = '0;
    w_regs_nxt[0] = '0;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      r_regs <= w_regs_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_mp_rdport #(
      .XLEN(XLEN), .NREG(NREG), .NWR(NWR), .BYPASS(BYPASS), .AW(AW)
    ) u_rd (
      .i_regs   (r_regs),
      .i_busy   (r_busy),
      .i_wr_en  (wr_en),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .i_addr   (rd_addr[i*AW +: AW]),
      .o_data   (rd_data[i*XLEN +: XLEN]),
      .o_busy   (rd_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: one DUT with forwarding, one without, sharing stimulus.
module tb_regfile_mp;
  localparam int XLEN = 32, NREG = 32, NRD = 2, NWR = 2, AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data1, rd_data0;
  logic [NRD-1:0]      rd_busy1, rd_busy0;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                resv_en;
  logic [AW-1:0]       resv_addr;
  logic                flush;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr), .flush(flush));

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr), .flush(flush));

  typedef struct {
    int                  cyc;
    logic [NRD*XLEN-1:0] d1, d0;
    logic [NRD-1:0]      b1, b0;
  } exp_t;

  exp_t            q[$];
  logic [XLEN-1:0] m_reg[NREG];
  bit              m_busy[NREG];
  int              n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(string nm, int c, int i, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d port=%0d got=%h expected=%h", nm, c, i, act, exp);
  endtask

  // Reference model: array of registers and busy flags.
  function automatic logic [XLEN-1:0] m_rdata(int i, bit byp);
    logic [AW-1:0] a;
    a = rd_addr[i*AW +: AW];
    if (a == 0) return '0;
    if (byp)
      for (int p = NWR-1; p >= 0; p--)
        if (wr_en[p] && wr_addr[p*AW +: AW] == a) return wr_data[p*XLEN +: XLEN];
    return m_reg[a];
  endfunction

  function automatic bit m_rbusy(int i, bit byp);
    logic [AW-1:0] a;
    bit hit;
    a = rd_addr[i*AW +: AW];
    hit = 1'b0;
    if (a == 0) return 1'b0;
    for (int p = 0; p < NWR; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] == a) hit = 1'b1;
    return m_busy[a] && !(byp && hit);
  endfunction

  task automatic model_commit();
    for (int a = 1; a < NREG; a++) begin
      for (int p = NWR-1; p >= 0; p--)
        if (wr_en[p] && wr_addr[p*AW +: AW] == a[AW-1:0]) begin
          m_reg[a] = wr_data[p*XLEN +: XLEN];
          m_busy[a] = 1'b0;
          break;
        end
    end
    if (resv_en && resv_addr != 0) m_busy[resv_addr] = 1'b1;
    if (flush) for (int a = 0; a < NREG; a++) m_busy[a] = 1'b0;
  endtask

  task automatic issue();
    exp_t e;
    if (rst) for (int a = 0; a < NREG; a++) begin m_reg[a] = '0; m_busy[a] = 1'b0; end
    e.cyc = cyc;
    for (int i = 0; i < NRD; i++) begin
      e.d1[i*XLEN +: XLEN] = m_rdata(i, 1'b1);
      e.d0[i*XLEN +: XLEN] = m_rdata(i, 1'b0);
      e.b1[i] = m_rbusy(i, 1'b1);
      e.b0[i] = m_rbusy(i, 1'b0);
    end
    q.push_back(e);
    if (!rst) model_commit();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    resv_en = 1'b0; resv_addr = '0; flush = 1'b0;
    cyc++;
  endtask

  task automatic set_rd(int i, int a);
    rd_addr[i*AW +: AW] = a[AW-1:0];
  endtask

  task automatic set_wr(int p, int a, logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a[AW-1:0];
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_resv(int a);
    resv_en = 1'b1;
    resv_addr = a[AW-1:0];
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int i = 0; i < NRD; i++) begin
        chk("rd_data_bypass", e.cyc, i, rd_data1[i*XLEN +: XLEN], e.d1[i*XLEN +: XLEN]);
        chk("rd_busy_bypass", e.cyc, i, {31'b0, rd_busy1[i]}, {31'b0, e.b1[i]});
        chk("rd_data_nobypass", e.cyc, i, rd_data0[i*XLEN +: XLEN], e.d0[i*XLEN +: XLEN]);
        chk("rd_busy_nobypass", e.cyc, i, {31'b0, rd_busy0[i]}, {31'b0, e.b0[i]});
      end
    end
  end

  initial begin
    rd_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0;
    resv_en = 1'b0; resv_addr = '0; flush = 1'b0;
    for (int a = 0; a < NREG; a++) begin m_reg[a] = '0; m_busy[a] = 1'b0; end

    // Reset state; a write presented during reset is forwarded but discarded.
    next(); set_rd(0, 3); set_rd(1, 7); set_wr(0, 3, 32'h99); set_resv(7); issue();
    next(); rst = 1'b0; set_rd(0, 3); set_rd(1, 7); issue();

    // Same-address write priority.
    next(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7); set_rd(1, 7); issue();
    next(); set_rd(0, 7); set_rd(1, 7); issue();

    // x0 protection.
    next(); set_wr(0, 0, 32'hFFFF_FFFF); set_resv(0); set_rd(0, 0); set_rd(1, 0); issue();
    next(); set_rd(0, 0); set_rd(1, 0); issue();

    // Reservation then producer writeback.
    next(); set_resv(3); set_rd(0, 3); issue();
    next(); set_rd(0, 3); set_rd(1, 3); issue();
    next(); set_wr(1, 3, 32'h42); set_rd(0, 3); issue();
    next(); set_rd(0, 3); issue();

    // Reserve/write collision, then flush.
    next(); set_resv(9); set_wr(0, 9, 32'h5); set_rd(1, 9); issue();
    next(); set_rd(0, 9); flush = 1'b1; set_resv(10); issue();
    next(); set_rd(0, 9); set_rd(1, 10); issue();

    // Forwarding vs. pre-write value, distinct-address dual write.
    next(); set_wr(0, 4, 32'hA); set_wr(1, 6, 32'hB); set_rd(0, 4); set_rd(1, 6); issue();
    next(); set_rd(0, 4); set_rd(1, 6); issue();

    // Asynchronous reset mid-cycle clears stored data before any edge.
    next(); set_wr(0, 5, 32'hDEAD_BEEF); set_rd(0, 5); issue();
    next(); set_rd(0, 5); issue();
    next(); rst = 1'b1; set_rd(0, 5); set_rd(1, 7); issue();
    next(); rst = 1'b0; set_rd(0, 5); set_rd(1, 7); issue();

    for (int n = 0; n < 400; n++) begin
      int r;
      next();
      r = $urandom_range(0, 59);
      rst = (r == 0);
      for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, 7));
      for (int p = 0; p < NWR; p++)
        if ($urandom_range(0, 1) == 1) set_wr(p, $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 2) == 0) set_resv($urandom_range(0, 7));
      flush = ($urandom_range(0, 9) == 0);
      issue();
    end

    next();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
